// File: rtl/risc_pkg.sv
// Shared definitions for the processor support blocks: loader FSM encoding and
// default memory/stream geometry.
package risc_pkg;

    localparam int AWIDTH_DEF  = 5;
    localparam int DWIDTH_DEF  = 8;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear (load) and count enable (enab).
module counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= '0;
        end else if (enab) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed, checksummed byte stream,
// writes it into program memory and releases the processor reset on success.
module prog_loader
    import risc_pkg::*;
#(
    parameter int AWIDTH  = AWIDTH_DEF,
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam int MAX_LEN = 1 << AWIDTH;

    // Stream handshake: a byte moves on every cycle where in_valid and in_ready
    // are both high; in_ready is a registered decode of the session states.
    state_t            state;
    state_t            state_next;
    logic              xfer;
    logic              active;
    logic              len_ok;
    logic              timed_out;
    logic [AWIDTH-1:0] addr;
    logic [AWIDTH-1:0] last_addr;
    logic [DWIDTH-1:0] sum;
    logic [DWIDTH-1:0] csum_total;
    logic [TW-1:0]     idle_cnt;

    assign xfer       = in_valid & in_ready;
    assign active     = (state == LEN) || (state == DATA) || (state == CSUM);
    assign len_ok     = (in_data != '0) && (int'(in_data) <= MAX_LEN);
    assign timed_out  = active && !xfer && (idle_cnt == TW'(TIMEOUT - 1));
    assign csum_total = sum + in_data;

    counter #(.WIDTH(AWIDTH)) u_addr (
        .clk  (clk),
        .rst  (rst),
        .load ((state == LEN) && xfer && len_ok),
        .enab ((state == DATA) && xfer),
        .q    (addr)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LEN;
            LEN: begin
                if (timed_out)  state_next = ERR;
                else if (xfer)  state_next = len_ok ? DATA : ERR;
            end
            DATA: begin
                if (timed_out)                      state_next = ERR;
                else if (xfer && addr == last_addr) state_next = CSUM;
            end
            CSUM: begin
                if (timed_out) state_next = ERR;
                else if (xfer) state_next = (csum_total == '0) ? DONE : ERR;
            end
            DONE, ERR: if (start) state_next = LEN;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            sum       <= '0;
            last_addr <= '0;
            idle_cnt  <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == LEN) || (state_next == DATA) || (state_next == CSUM);
            cpu_rst  <= (state_next != DONE);
            done     <= (state_next == DONE);
            err      <= (state_next == ERR);
            mem_wr   <= (state == DATA) && xfer;

            if ((state == LEN) && xfer && len_ok) begin
                sum       <= '0;
                last_addr <= AWIDTH'(in_data - 1'b1);
            end

            if ((state == DATA) && xfer) begin
                mem_addr <= addr;
                mem_data <= in_data;
                sum      <= sum + in_data;
            end

            if (!active || xfer) idle_cnt <= '0;
            else                 idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of whole load sessions plus hand-written
// timeout, mid-session reset and start/in_valid collision sequences.
module tb_prog_loader;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          cpu_rst;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] got_q[$];

    typedef struct {
        logic [7:0] len;
        logic [7:0] base;
        logic [7:0] step;
        int         ndata;
        logic       send_csum;
        logic [7:0] csum;
        logic       exp_done;
        logic       exp_err;
        int         exp_writes;
    } vec_t;

    vec_t vecs[7];

    prog_loader #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(255)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before 2ms");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (mem_wr === 1'b1) got_q.push_back({mem_addr, mem_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && k < 8) begin
            tick(1);
            k++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_wr_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_wr_entry"}, got_q[i], exp_q[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_mem_wr"},   {31'd0, mem_wr},   32'd0);
        check({tag, "_mem_addr"}, {27'd0, mem_addr}, 32'd0);
        check({tag, "_mem_data"}, {24'd0, mem_data}, 32'd0);
        check({tag, "_cpu_rst"},  {31'd0, cpu_rst},  32'd1);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_err"},      {31'd0, err},      32'd0);
    endtask

    task automatic run_session(input vec_t v);
        logic [7:0] b;
        got_q.delete();
        exp_q.delete();
        do_start();
        send_byte(v.len);
        for (int i = 0; i < v.ndata; i++) begin
            b = v.base + v.step * 8'(i);
            send_byte(b);
            if (i < v.exp_writes) exp_q.push_back({i[AW-1:0], b});
        end
        if (v.ndata > 0) check("cpu_rst_before_csum", {31'd0, cpu_rst}, 32'd1);
        if (v.send_csum) send_byte(v.csum);
        check("done", {31'd0, done}, {31'd0, v.exp_done});
        check("err", {31'd0, err}, {31'd0, v.exp_err});
        check("cpu_rst", {31'd0, cpu_rst}, {31'd0, !v.exp_done});
        tick(2);
        check("in_ready_after", {31'd0, in_ready}, 32'd0);
        compare_writes("session");
    endtask

    initial begin
        //              len    base   step   nd  csum? csum   done  err  writes
        vecs[0] = '{8'h03, 8'h11, 8'h11, 3,  1'b1, 8'h9A, 1'b1, 1'b0, 3};
        vecs[1] = '{8'h03, 8'h11, 8'h11, 3,  1'b1, 8'h9B, 1'b0, 1'b1, 3};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 0,  1'b0, 8'h00, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h21, 8'h00, 8'h00, 0,  1'b0, 8'h00, 1'b0, 1'b1, 0};
        vecs[4] = '{8'h20, 8'h01, 8'h00, 32, 1'b1, 8'hE0, 1'b1, 1'b0, 32};
        vecs[5] = '{8'h01, 8'h80, 8'h00, 1,  1'b1, 8'h80, 1'b1, 1'b0, 1};
        vecs[6] = '{8'h02, 8'h05, 8'h01, 2,  1'b1, 8'hF5, 1'b1, 1'b0, 2};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(2);
        check_reset_outputs("idle");

        // start and in_valid together in IDLE: the byte must not count as length
        got_q.delete();
        exp_q.delete();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h02;
        tick(1);
        start    = 1'b0;
        in_valid = 1'b0;
        check("len_state_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h01);
        send_byte(8'h7F);
        send_byte(8'h81);
        check("collide_done", {31'd0, done}, 32'd1);
        exp_q.push_back({5'd0, 8'h7F});
        tick(2);
        compare_writes("collide");

        foreach (vecs[i]) run_session(vecs[i]);

        // timeout after two DATA bytes, then recovery with an ignored start mid-DATA
        got_q.delete();
        exp_q.delete();
        do_start();
        send_byte(8'h04);
        send_byte(8'h10);
        send_byte(8'h20);
        tick(254);
        check("timeout_not_yet", {31'd0, err}, 32'd0);
        check("timeout_ready", {31'd0, in_ready}, 32'd1);
        tick(1);
        check("timeout_err", {31'd0, err}, 32'd1);
        check("timeout_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        exp_q.push_back({5'd0, 8'h10});
        exp_q.push_back({5'd1, 8'h20});
        compare_writes("timeout");

        got_q.delete();
        exp_q.delete();
        do_start();
        check("restart_err_low", {31'd0, err}, 32'd0);
        send_byte(8'h03);
        send_byte(8'h11);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h9A);
        check("recover_done", {31'd0, done}, 32'd1);
        exp_q.push_back({5'd0, 8'h11});
        exp_q.push_back({5'd1, 8'h22});
        exp_q.push_back({5'd2, 8'h33});
        tick(2);
        compare_writes("recover");

        // reset pulsed right after the second DATA byte is accepted
        got_q.delete();
        exp_q.delete();
        do_start();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick(2);
        #1 rst = 1'b0;
        tick(3);
        check_reset_outputs("midrst_after");
        exp_q.push_back({5'd0, 8'h11});
        compare_writes("midrst");
        run_session(vecs[6]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
